// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared widths, IR field positions, opcodes, operand_seq states.
//               State set depends on OPERAND_SEQ_INDIRECT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int C_DATA_WIDTH = 16;
    localparam int C_ADDR_WIDTH = 6;

    localparam int C_IR_OC_MSB = 15;
    localparam int C_IR_OC_LSB = 12;
    localparam int C_IR_DI_X   = 11;
    localparam int C_IR_AX_MSB = 10;
    localparam int C_IR_AX_LSB = 8;
    localparam int C_IR_DI_Y   = 7;
    localparam int C_IR_AY_MSB = 6;
    localparam int C_IR_AY_LSB = 4;
    localparam int C_IR_DI_Z   = 3;
    localparam int C_IR_AZ_MSB = 2;
    localparam int C_IR_AZ_LSB = 0;

    localparam logic [3:0] C_OC_NOP = 4'h0;
    localparam logic [3:0] C_OC_ADD = 4'h1;
    localparam logic [3:0] C_OC_SUB = 4'h2;
    localparam logic [3:0] C_OC_AND = 4'h3;
    localparam logic [3:0] C_OC_OR  = 4'h4;
    localparam logic [3:0] C_OC_MOV = 4'h5;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        OP_ADDR  = 4'd1,
        OP_RD    = 4'd2,
`ifdef OPERAND_SEQ_INDIRECT_EN
        IND_ADDR = 4'd3,
        IND_RD   = 4'd4,
        WB_PADDR = 4'd5,
        WB_PRD   = 4'd6,
`endif
        WB_WRITE = 4'd7,
        DONE     = 4'd8
    } opseq_state_t;

    // Returns {found, index} of the lowest set mask bit at or above 'from'.
    function automatic logic [2:0] next_op(input logic [2:0] sel, input logic [1:0] from);
        logic [2:0] v_res;
        v_res = 3'b000;
        for (int i = 2; i >= 0; i--) begin
            if (sel[i] && (i >= int'(from))) begin
                v_res = {1'b1, 2'(i)};
            end
        end
        return v_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/operand_seq.sv
`default_nettype none
// ============================================================================
// Module      : operand_seq
// Description : Fetches x/y/z operands from memory and writes back results;
//               indirect addressing enabled by OPERAND_SEQ_INDIRECT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_seq
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int ADDR_WIDTH = C_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] ir,
    input  logic [2:0]            mask,
    input  logic                  wb_start,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] op_x,
    output logic [DATA_WIDTH-1:0] op_y,
    output logic [DATA_WIDTH-1:0] op_z,
    output logic                  busy,
    output logic                  done
);

    opseq_state_t                r_state;
    opseq_state_t                w_state_next;
    logic [C_IR_DI_X:0]          r_ir;
    logic [2:0]                  r_mask;
    logic [1:0]                  r_idx;
    logic [DATA_WIDTH-1:0]       r_wb_data;
    logic [DATA_WIDTH-1:0]       r_op_x, r_op_y, r_op_z;
    logic [2:0]                  w_first, w_adv;
    logic [2:0]                  w_field;
    logic [ADDR_WIDTH-1:0]       w_ax, w_wb_target;
    logic                        w_load;
    logic                        w_unused;

    function automatic logic [ADDR_WIDTH-1:0] zext(input logic [2:0] f);
        return ADDR_WIDTH'(f);
    endfunction

    assign w_first = next_op(mask, 2'd0);
    assign w_adv   = next_op(r_mask, r_idx + 2'd1);
    assign w_ax    = zext(r_ir[C_IR_AX_MSB:C_IR_AX_LSB]);

    always_comb begin
        w_field = r_ir[C_IR_AX_MSB:C_IR_AX_LSB];
        case (r_idx)
            2'd1:    w_field = r_ir[C_IR_AY_MSB:C_IR_AY_LSB];
            2'd2:    w_field = r_ir[C_IR_AZ_MSB:C_IR_AZ_LSB];
            default: w_field = r_ir[C_IR_AX_MSB:C_IR_AX_LSB];
        endcase
    end

`ifdef OPERAND_SEQ_INDIRECT_EN
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  w_di;

    always_comb begin
        w_di = r_ir[C_IR_DI_X];
        case (r_idx)
            2'd1:    w_di = r_ir[C_IR_DI_Y];
            2'd2:    w_di = r_ir[C_IR_DI_Z];
            default: w_di = r_ir[C_IR_DI_X];
        endcase
    end

    assign w_load      = ((r_state == OP_RD) && !w_di) || (r_state == IND_RD);
    assign w_wb_target = r_ir[C_IR_DI_X] ? r_ptr : w_ax;
    assign w_unused    = ^ir[DATA_WIDTH-1:C_IR_DI_X+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (((r_state == OP_RD) && w_di) || (r_state == WB_PRD)) begin
            r_ptr <= mem_rdata[ADDR_WIDTH-1:0];
        end
    end
`else
    assign w_load      = (r_state == OP_RD);
    assign w_wb_target = w_ax;
    // Direct-only build: the di bits are latched but deliberately ignored.
    assign w_unused    = ^{ir[DATA_WIDTH-1:C_IR_DI_X+1], r_ir[C_IR_DI_X], r_ir[C_IR_DI_Y], r_ir[C_IR_DI_Z]};
`endif

    always_comb begin
        w_state_next = r_state;
        mem_addr     = '0;
        mem_we       = 1'b0;
        mem_wdata    = '0;
        case (r_state)
            IDLE: begin
                if (wb_start) begin
`ifdef OPERAND_SEQ_INDIRECT_EN
                    w_state_next = ir[C_IR_DI_X] ? WB_PADDR : WB_WRITE;
`else
                    w_state_next = WB_WRITE;
`endif
                end else if (start) begin
                    w_state_next = w_first[2] ? OP_ADDR : DONE;
                end
            end
            OP_ADDR: begin
                mem_addr     = zext(w_field);
                w_state_next = OP_RD;
            end
            OP_RD: begin
                mem_addr = zext(w_field);
`ifdef OPERAND_SEQ_INDIRECT_EN
                if (w_di) w_state_next = IND_ADDR;
                else
`endif
                w_state_next = w_adv[2] ? OP_ADDR : DONE;
            end
`ifdef OPERAND_SEQ_INDIRECT_EN
            IND_ADDR: begin
                mem_addr     = r_ptr;
                w_state_next = IND_RD;
            end
            IND_RD: begin
                mem_addr     = r_ptr;
                w_state_next = w_adv[2] ? OP_ADDR : DONE;
            end
            WB_PADDR: begin
                mem_addr     = w_ax;
                w_state_next = WB_PRD;
            end
            WB_PRD: begin
                mem_addr     = w_ax;
                w_state_next = WB_WRITE;
            end
`endif
            WB_WRITE: begin
                mem_addr     = w_wb_target;
                mem_we       = 1'b1;
                mem_wdata    = r_wb_data;
                w_state_next = DONE;
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ir      <= '0;
            r_mask    <= '0;
            r_idx     <= '0;
            r_wb_data <= '0;
        end else begin
            r_state <= w_state_next;
            // wb_start has priority; commands outside IDLE are dropped.
            if (r_state == IDLE) begin
                if (wb_start) begin
                    r_ir      <= ir[C_IR_DI_X:0];
                    r_wb_data <= wb_data;
                end else if (start) begin
                    r_ir   <= ir[C_IR_DI_X:0];
                    r_mask <= mask;
                    r_idx  <= w_first[1:0];
                end
            end else if (w_load) begin
                r_idx <= w_adv[1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_x <= '0;
            r_op_y <= '0;
            r_op_z <= '0;
        end else if (w_load) begin
            case (r_idx)
                2'd0:    r_op_x <= mem_rdata;
                2'd1:    r_op_y <= mem_rdata;
                2'd2:    r_op_z <= mem_rdata;
                default: ;
            endcase
        end
    end

    assign op_x = r_op_x;
    assign op_y = r_op_y;
    assign op_z = r_op_z;
    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_operand_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_seq
// Description : Directed vector bench for operand_seq with a behavioural memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_seq;

`ifdef OPERAND_SEQ_INDIRECT_EN
    localparam bit IND = 1'b1;
`else
    localparam bit IND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] ir = '0;
    logic [2:0]  mask = '0;
    logic        wb_start = 1'b0;
    logic [15:0] wb_data = '0;
    logic [5:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] op_x, op_y, op_z;
    logic        busy, done;

    logic        pre_we = 1'b0;
    logic [5:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;
    logic [15:0] mem [0:63];
    logic [5:0]  trace [0:63];

    int checks = 0;
    int errors = 0;

    operand_seq #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ir(ir), .mask(mask),
        .wb_start(wb_start), .wb_data(wb_data), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .op_x(op_x), .op_y(op_y), .op_z(op_z), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic [15:0]      ir;
        logic [2:0]       mask;
        logic             st;
        logic             wb;
        logic [15:0]      wbd;
        int               npre;
        logic [2:0][5:0]  pa;
        logic [2:0][15:0] pd;
        int               lat;
        logic [15:0]      ex, ey, ez;
        logic             mchk;
        logic [5:0]       maddr;
        logic [15:0]      mdata;
        int               nwe;
    } vec_t;

    vec_t vt [9];

    function automatic vec_t mk(
        input logic [15:0] f_ir, input logic [2:0] f_mask, input logic f_st, input logic f_wb,
        input logic [15:0] f_wbd, input int f_npre, input logic [2:0][5:0] f_pa,
        input logic [2:0][15:0] f_pd, input int f_lat, input logic [15:0] f_ex,
        input logic [15:0] f_ey, input logic [15:0] f_ez, input logic f_mchk,
        input logic [5:0] f_maddr, input logic [15:0] f_mdata, input int f_nwe);
        vec_t v;
        v.ir = f_ir; v.mask = f_mask; v.st = f_st; v.wb = f_wb; v.wbd = f_wbd;
        v.npre = f_npre; v.pa = f_pa; v.pd = f_pd; v.lat = f_lat;
        v.ex = f_ex; v.ey = f_ey; v.ez = f_ez;
        v.mchk = f_mchk; v.maddr = f_maddr; v.mdata = f_mdata; v.nwe = f_nwe;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pre(input logic [5:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic clear_inputs();
        start = 1'b0; wb_start = 1'b0; ir = '0; mask = '0; wb_data = '0;
    endtask

    // Latency k means done is seen high in the k-th cycle after the command edge.
    task automatic run_cmd(input logic [15:0] t_ir, input logic [2:0] t_mask, input logic t_st,
                           input logic t_wb, input logic [15:0] t_wbd, input bit interfere,
                           output int lat, output int nwe);
        lat = -1;
        nwe = 0;
        @(negedge clk);
        ir = t_ir; mask = t_mask; start = t_st; wb_start = t_wb; wb_data = t_wbd;
        @(posedge clk); #1;
        clear_inputs();
        if (interfere) begin
            start = 1'b1; wb_start = 1'b1; ir = 16'h0200; mask = 3'b111; wb_data = 16'hDEAD;
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 2) clear_inputs();
            trace[k] = mem_addr;
            if (mem_we) nwe++;
            if (done) begin
                lat = k;
                break;
            end
        end
        clear_inputs();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, nwe, seen;
        logic [15:0] keep_x, keep_z;

        vt[0] = mk(16'h0123, 3'b000, 1'b1, 1'b0, 16'h0, 0, '0, '0,
                   1, 16'h0, 16'h0, 16'h0, 1'b0, 6'h0, 16'h0, 0);
        vt[1] = mk(16'h0100, 3'b001, 1'b1, 1'b0, 16'h0, 1, {6'd0, 6'd0, 6'd1}, {16'h0, 16'h0, 16'h0005},
                   3, 16'h0005, 16'h0, 16'h0, 1'b0, 6'h0, 16'h0, 0);
        vt[2] = mk(16'h00A0, 3'b010, 1'b1, 1'b0, 16'h0, 2, {6'd0, 6'h20, 6'd2}, {16'h0, 16'hBEEF, 16'h0020},
                   IND ? 5 : 3, 16'h0005, IND ? 16'hBEEF : 16'h0020, 16'h0, 1'b0, 6'h0, 16'h0, 0);
        vt[3] = mk(16'h0123, 3'b111, 1'b1, 1'b0, 16'h0, 3, {6'd3, 6'd2, 6'd1}, {16'h0033, 16'h0022, 16'h0011},
                   7, 16'h0011, 16'h0022, 16'h0033, 1'b0, 6'h0, 16'h0, 0);
        vt[4] = mk(16'h0456, 3'b101, 1'b1, 1'b0, 16'h0, 2, {6'd0, 6'd6, 6'd4}, {16'h0, 16'hCCCC, 16'hAAAA},
                   5, 16'hAAAA, 16'h0022, 16'hCCCC, 1'b0, 6'h0, 16'h0, 0);
        vt[5] = mk(16'h000F, 3'b100, 1'b1, 1'b0, 16'h0, 1, {6'd0, 6'd0, 6'd7}, {16'h0, 16'h0, 16'h0007},
                   IND ? 5 : 3, 16'hAAAA, 16'h0022, 16'h0007, 1'b0, 6'h0, 16'h0, 0);
        vt[6] = mk(16'h0900, 3'b001, 1'b1, 1'b0, 16'h0, 2, {6'd0, 6'd0, 6'd1}, {16'h0, 16'h5A5A, 16'h0000},
                   IND ? 5 : 3, IND ? 16'h5A5A : 16'h0000, 16'h0022, 16'h0007, 1'b0, 6'h0, 16'h0, 0);
        vt[7] = mk(16'h0300, 3'b000, 1'b0, 1'b1, 16'h0F0F, 0, '0, '0,
                   2, IND ? 16'h5A5A : 16'h0000, 16'h0022, 16'h0007, 1'b1, 6'd3, 16'h0F0F, 1);
        vt[8] = mk(16'h0C00, 3'b111, 1'b1, 1'b1, 16'h1234, 1, {6'd0, 6'd0, 6'd4}, {16'h0, 16'h0, 16'h0030},
                   IND ? 4 : 2, IND ? 16'h5A5A : 16'h0000, 16'h0022, 16'h0007,
                   1'b1, IND ? 6'h30 : 6'd4, 16'h1234, 1);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_op_x", 32'(op_x), 32'd0);
        chk("rst_op_y", 32'(op_y), 32'd0);
        chk("rst_op_z", 32'(op_z), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            for (int p = 0; p < vt[i].npre; p++) pre(vt[i].pa[p], vt[i].pd[p]);
            run_cmd(vt[i].ir, vt[i].mask, vt[i].st, vt[i].wb, vt[i].wbd, 1'b0, lat, nwe);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("v%0d_mem_we_count", i), 32'(nwe), 32'(vt[i].nwe));
            @(negedge clk);
            chk($sformatf("v%0d_done_single", i), 32'(done), 32'd0);
            chk($sformatf("v%0d_busy_after", i), 32'(busy), 32'd0);
            chk($sformatf("v%0d_op_x", i), 32'(op_x), 32'(vt[i].ex));
            chk($sformatf("v%0d_op_y", i), 32'(op_y), 32'(vt[i].ey));
            chk($sformatf("v%0d_op_z", i), 32'(op_z), 32'(vt[i].ez));
            if (vt[i].mchk) chk($sformatf("v%0d_mem_write", i), 32'(mem[vt[i].maddr]), 32'(vt[i].mdata));
            if (i == 3) begin
                chk("v3_addr_x", 32'(trace[1]), 32'd1);
                chk("v3_addr_y", 32'(trace[3]), 32'd2);
                chk("v3_addr_z", 32'(trace[5]), 32'd3);
            end
        end

        // Commands presented while busy must be ignored entirely
        keep_x = op_x;
        keep_z = op_z;
        pre(6'd2, 16'h4444);
        run_cmd(16'h0020, 3'b010, 1'b1, 1'b0, 16'h0, 1'b1, lat, nwe);
        chk("busy_ign_latency", 32'(lat), 32'd3);
        chk("busy_ign_mem_we", 32'(nwe), 32'd0);
        @(negedge clk);
        chk("busy_ign_op_y", 32'(op_y), 32'h4444);
        chk("busy_ign_op_x", 32'(op_x), 32'(keep_x));
        chk("busy_ign_op_z", 32'(op_z), 32'(keep_z));
        chk("busy_ign_mem2", 32'(mem[2]), 32'h4444);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy || done) seen++;
        end
        chk("busy_ign_no_queue", 32'(seen), 32'd0);

        // Reset mid-fetch: IND_RD with indirection, OP_RD otherwise
        pre(6'd2, 16'h0020);
        pre(6'h20, 16'hBEEF);
        @(negedge clk);
        ir = 16'h00A0; mask = 3'b010; start = 1'b1;
        @(posedge clk); #1;
        clear_inputs();
        repeat (IND ? 4 : 2) @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_op_y", 32'(op_y), 32'd0);
        chk("midrst_op_x", 32'(op_x), 32'd0);
        chk("midrst_mem_we", 32'(mem_we), 32'd0);
        chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || done) seen++;
        end
        chk("midrst_no_resume", 32'(seen), 32'd0);
        chk("midrst_op_y_stays", 32'(op_y), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
